// File: rtl/decade_chain_pkg.sv
// Shared defaults and load-sanitising helper for the cascaded modulo-MOD digit chain.
package decade_chain_pkg;

  localparam int unsigned MOD_DEF    = 10;
  localparam int unsigned DIG_W_DEF  = 4;
  localparam int unsigned DIGITS_DEF = 4;

  // A digit value at or above the modulus is not a legal count and loads as 0.
  function automatic logic digit_illegal(input int unsigned d, input int unsigned m);
    return d >= m;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// One modulo-MOD counter digit with clear, sanitised load and carry-in increment.
module decade_digit
  import decade_chain_pkg::*;
#(
  parameter int unsigned MOD   = MOD_DEF,
  parameter int unsigned DIG_W = DIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [DIG_W-1:0] ld_d,
  input  logic             inc,
  output logic [DIG_W-1:0] q,
  output logic             tc
);

  localparam logic [DIG_W-1:0] LAST = DIG_W'(MOD - 1);

  assign tc = (q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= digit_illegal(32'(ld_d), MOD) ? '0 : ld_d;
    end else if (inc) begin
      q <= tc ? '0 : q + DIG_W'(1);
    end
  end

endmodule

// File: rtl/decade_chain_cnt.sv
// Cascaded modulo-MOD counter chain with synchronous carry, load, clear and overflow pulse.
// Define DECADE_CHAIN_SAT_EN to saturate at all-(MOD-1) and expose a sticky sat output.
module decade_chain_cnt
  import decade_chain_pkg::*;
#(
  parameter int unsigned MOD    = MOD_DEF,
  parameter int unsigned DIG_W  = DIG_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    ld,
  input  logic [DIGITS*DIG_W-1:0] ld_val,
  output logic [DIGITS*DIG_W-1:0] cnt,
  output logic [DIGITS-1:0]       tc,
  output logic                    ovf
`ifdef DECADE_CHAIN_SAT_EN
  ,
  output logic                    sat
`endif
);

  logic             en_q;
  logic             full;
  logic [DIGITS-1:0] inc;

  assign full = &tc;

`ifdef DECADE_CHAIN_SAT_EN
  // Suppress the tick at terminal count so the chain holds instead of wrapping.
  assign en_q = en && !full;
`else
  assign en_q = en;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign inc[i] = en_q;
    end else begin : g_upper
      assign inc[i] = en_q && (&tc[i-1:0]);
    end

    decade_digit #(
      .MOD   (MOD),
      .DIG_W (DIG_W)
    ) u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .ld   (ld),
      .ld_d (ld_val[i*DIG_W +: DIG_W]),
      .inc  (inc[i]),
      .q    (cnt[i*DIG_W +: DIG_W]),
      .tc   (tc[i])
    );
  end

  // Full-chain wrap pulse, lands in the same cycle cnt returns to zero.
  always_ff @(posedge clk) begin
    if (rst || clr || ld) begin
      ovf <= 1'b0;
    end else begin
`ifdef DECADE_CHAIN_SAT_EN
      ovf <= 1'b0;
`else
      ovf <= en && full;
`endif
    end
  end

`ifdef DECADE_CHAIN_SAT_EN
  always_ff @(posedge clk) begin
    if (rst || clr || ld) begin
      sat <= 1'b0;
    end else if (en && full) begin
      sat <= 1'b1;
    end
  end
`endif

endmodule
